// File: rtl/cluster_task_dispatcher_pkg.sv
// cluster_task_dispatcher_pkg: descriptor types and defaults shared by the cluster dispatcher slice.
package cluster_task_dispatcher_pkg;
    localparam int DEFAULT_NUM_HPUS = 8;
    localparam int MSGID_W          = 10;
    localparam int ADDR_W           = 32;

    typedef struct packed {
        logic [MSGID_W-1:0] msgid;
        logic [ADDR_W-1:0]  handler_fun;
        logic [ADDR_W-1:0]  pkt_addr;
    } handler_task_t;

    typedef struct packed {
        logic [MSGID_W-1:0] msgid;
        logic [ADDR_W-1:0]  pkt_addr;
    } feedback_descr_t;

    function automatic feedback_descr_t to_feedback(input handler_task_t t);
        return '{msgid: t.msgid, pkt_addr: t.pkt_addr};
    endfunction
endpackage

// File: rtl/cluster_task_dispatcher_if.sv
// cluster_task_dispatcher_if: scheduler task, HPU dispatch/completion and feedback signals of one cluster.
interface cluster_task_dispatcher_if #(
    parameter int NUM_HPUS = cluster_task_dispatcher_pkg::DEFAULT_NUM_HPUS
);
    import cluster_task_dispatcher_pkg::*;
    logic                task_valid_i;
    logic                task_ready_o;
    handler_task_t       task_descr_i;
    logic [NUM_HPUS-1:0] hpu_task_valid_o;
    logic [NUM_HPUS-1:0] hpu_task_ready_i;
    handler_task_t       hpu_task_o;
    logic [NUM_HPUS-1:0] hpu_done_i;
    logic                feedback_valid_o;
    logic                feedback_ready_i;
    feedback_descr_t     feedback_o;
    logic [NUM_HPUS-1:0] busy_o;

    modport slave (
        input  task_valid_i, task_descr_i, hpu_task_ready_i, hpu_done_i, feedback_ready_i,
        output task_ready_o, hpu_task_valid_o, hpu_task_o, feedback_valid_o, feedback_o, busy_o
    );
    modport master (
        output task_valid_i, task_descr_i, hpu_task_ready_i, hpu_done_i, feedback_ready_i,
        input  task_ready_o, hpu_task_valid_o, hpu_task_o, feedback_valid_o, feedback_o, busy_o
    );
endinterface

// File: rtl/cluster_task_dispatcher_fifo.sv
// cluster_task_dispatcher_fifo: registered (non fall-through) feedback queue; output reads zero while empty.
module cluster_task_dispatcher_fifo
    import cluster_task_dispatcher_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            push_i,
    input  feedback_descr_t data_i,
    output logic            full_o,
    input  logic            pop_i,
    output logic            empty_o,
    output feedback_descr_t data_o
);
    localparam int AW = $clog2(DEPTH);
    feedback_descr_t r_mem [DEPTH];
    logic [AW-1:0]   r_wr, r_rd;
    logic [AW:0]     r_cnt;

    assign full_o  = r_cnt == (AW+1)'(DEPTH);
    assign empty_o = r_cnt == '0;
    assign data_o  = empty_o ? '0 : r_mem[r_rd];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
        end else begin
            if (push_i) r_wr <= r_wr + 1'b1;
            if (pop_i) r_rd <= r_rd + 1'b1;
            r_cnt <= r_cnt + (AW+1)'(push_i) - (AW+1)'(pop_i);
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_i) r_mem[r_wr] <= data_i;
    end
endmodule

// File: rtl/cluster_task_dispatcher.sv
// cluster_task_dispatcher: hands scheduler tasks to free HPUs and returns exactly one feedback per task.
// Define CLUSTER_DISPATCH_RR_EN for round-robin HPU choice; otherwise the lowest-index free HPU is used.
module cluster_task_dispatcher
    import cluster_task_dispatcher_pkg::*;
#(
    parameter int NUM_HPUS      = DEFAULT_NUM_HPUS,
    parameter int FB_FIFO_DEPTH = 8
) (
    input logic                      clk_i,
    input logic                      rst_ni,
    cluster_task_dispatcher_if.slave bus
);
    localparam int HW = $clog2(NUM_HPUS);
    typedef enum logic {Idle, Dispatch} state_e;

    state_e              r_state, w_state_next;
    handler_task_t       r_task;
    logic [HW-1:0]       r_hpu, w_free_idx, w_pend_idx;
    logic [NUM_HPUS-1:0] r_busy, r_pend, w_free, w_disp, w_push_mask;
    feedback_descr_t     r_slot [NUM_HPUS];
    logic                w_accept, w_handshake, w_push, w_full, w_empty;
`ifdef CLUSTER_DISPATCH_RR_EN
    logic [HW-1:0]       r_ptr;
`endif

    assign w_free      = ~r_busy;
    assign w_accept    = (r_state == Idle) && bus.task_valid_i && (|w_free);
    assign w_handshake = (r_state == Dispatch) && bus.hpu_task_ready_i[r_hpu];
    assign w_push      = (|r_pend) && !w_full;
    assign w_disp      = w_handshake ? NUM_HPUS'(1) << r_hpu : '0;
    assign w_push_mask = w_push ? NUM_HPUS'(1) << w_pend_idx : '0;
    assign bus.busy_o  = r_busy;
    assign bus.feedback_valid_o = !w_empty;

    // Descending scans so the last hit is the lowest index (or lowest offset from the RR pointer).
    always_comb begin
        w_free_idx = '0;
        w_pend_idx = '0;
        for (int k = NUM_HPUS - 1; k >= 0; k--) begin
`ifdef CLUSTER_DISPATCH_RR_EN
            if (w_free[r_ptr + HW'(k)]) w_free_idx = r_ptr + HW'(k);
`else
            if (w_free[k]) w_free_idx = HW'(k);
`endif
            if (r_pend[k]) w_pend_idx = HW'(k);
        end
    end

    always_comb begin
        w_state_next         = r_state;
        bus.task_ready_o     = 1'b0;
        bus.hpu_task_valid_o = '0;
        bus.hpu_task_o       = '0;
        if (r_state == Idle) begin
            bus.task_ready_o = w_accept;
            w_state_next     = w_accept ? Dispatch : Idle;
        end else begin
            bus.hpu_task_valid_o[r_hpu] = 1'b1;
            bus.hpu_task_o              = r_task;
            w_state_next                = w_handshake ? Idle : Dispatch;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) r_state <= Idle;
        else r_state <= w_state_next;
    end

    // A done pulse only marks pending; busy drops when the feedback actually enters the queue.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_task <= '0;
            r_hpu  <= '0;
            r_busy <= '0;
            r_pend <= '0;
            for (int k = 0; k < NUM_HPUS; k++) r_slot[k] <= '0;
        end else begin
            if (w_accept) begin
                r_task <= bus.task_descr_i;
                r_hpu  <= w_free_idx;
            end
            if (w_handshake) r_slot[r_hpu] <= to_feedback(r_task);
            r_busy <= (r_busy & ~w_push_mask) | w_disp;
            r_pend <= (r_pend & ~w_push_mask) | (bus.hpu_done_i & r_busy);
        end
    end

`ifdef CLUSTER_DISPATCH_RR_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) r_ptr <= '0;
        else if (w_handshake) r_ptr <= r_hpu + 1'b1;
    end
`endif

    cluster_task_dispatcher_fifo #(.DEPTH(FB_FIFO_DEPTH)) u_fb_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (w_push),
        .data_i  (r_slot[w_pend_idx]),
        .full_o  (w_full),
        .pop_i   (bus.feedback_valid_o && bus.feedback_ready_i),
        .empty_o (w_empty),
        .data_o  (bus.feedback_o)
    );

`ifndef SYNTHESIS
    always_ff @(posedge clk_i) begin
        if (rst_ni) assert ((bus.hpu_done_i & ~r_busy) == '0) else $error("done pulse on idle HPU");
    end
`endif
endmodule
